de2_70_cpu_oci_dct_packer: RTL and testbench



---
 rtl/de2_70_cpu_oci_dct_packer.sv | 89 ++++++++
 tb/tb_de2_70_cpu_oci_dct_packer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/de2_70_cpu_oci_dct_packer.sv
// Trace atom packer: gathers 2-bit atoms into 30-bit words, with a one-entry output register and drop reporting.
// Optional macro DCT_PACKER_DROP_CNT_EN enables the saturating drop counter; without it drop_count is tied to 0.
module de2_70_cpu_oci_dct_packer #(
  parameter int DROP_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  atom_valid,
  input  logic [1:0]            atom,
  input  logic                  flush,
  input  logic                  word_ready,
  output logic                  word_valid,
  output logic [29:0]           dct_buffer,
  output logic [3:0]            dct_count,
  output logic                  atom_drop,
  output logic [DROP_CNT_W-1:0] drop_count
);

  logic [29:0] acc;
  logic [3:0]  acc_cnt;
  logic        flush_pend;

  logic        accept;
  logic        drop;
  logic        slot_free;
  logic        handoff;
  logic [3:0]  n;
  logic [29:0] acc_nxt;

  always_comb begin
    accept    = atom_valid && (acc_cnt != 4'd15);
    drop      = atom_valid && (acc_cnt == 4'd15);
    n         = acc_cnt + {3'b000, accept};
    acc_nxt   = acc;
    if (accept) acc_nxt = acc | ({28'd0, atom} << {acc_cnt, 1'b0});
    slot_free = !word_valid || word_ready;
    handoff   = slot_free && ((n == 4'd15) || ((flush || flush_pend) && (n != 4'd0)));
  end

  // Accumulator stage: a blocked full word simply waits here until the slot frees
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc        <= '0;
      acc_cnt    <= '0;
      flush_pend <= 1'b0;
    end else if (handoff) begin
      acc        <= '0;
      acc_cnt    <= '0;
      flush_pend <= 1'b0;
    end else begin
      acc     <= acc_nxt;
      acc_cnt <= n;
      if (flush && (n != 4'd0)) flush_pend <= 1'b1;
    end
  end

  // Output stage: a same-cycle hand-off replaces the consumed word without a bubble
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_valid <= 1'b0;
      dct_buffer <= '0;
      dct_count  <= '0;
      atom_drop  <= 1'b0;
    end else begin
      atom_drop <= drop;
      if (handoff) begin
        word_valid <= 1'b1;
        dct_buffer <= acc_nxt;
        dct_count  <= n;
      end else if (word_ready) begin
        word_valid <= 1'b0;
      end
    end
  end

`ifdef DCT_PACKER_DROP_CNT_EN
  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (&v) ? v : v + {{(DROP_CNT_W-1){1'b0}}, 1'b1};
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     drop_count <= '0;
    else if (drop) drop_count <= sat_inc(drop_count);
  end
`else
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_de2_70_cpu_oci_dct_packer.sv
// Self-checking bench for de2_70_cpu_oci_dct_packer: vector table, hand sequences and a word scoreboard.
// Builds with or without DCT_PACKER_DROP_CNT_EN; the drop counter is 4 bits wide to reach saturation.
module tb_de2_70_cpu_oci_dct_packer;

  localparam int DCW = 4;
`ifdef DCT_PACKER_DROP_CNT_EN
  localparam int DC_MAX = 15;
`else
  localparam int DC_MAX = 0;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic           atom_valid;
  logic [1:0]     atom;
  logic           flush;
  logic           word_ready;
  logic           word_valid;
  logic [29:0]    dct_buffer;
  logic [3:0]     dct_count;
  logic           atom_drop;
  logic [DCW-1:0] drop_count;

  de2_70_cpu_oci_dct_packer #(.DROP_CNT_W(DCW)) dut (
    .clk        (clk),
    .reset      (reset),
    .atom_valid (atom_valid),
    .atom       (atom),
    .flush      (flush),
    .word_ready (word_ready),
    .word_valid (word_valid),
    .dct_buffer (dct_buffer),
    .dct_count  (dct_count),
    .atom_drop  (atom_drop),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [29:0] buf_v;
    logic [3:0]  cnt;
  } word_t;

  typedef struct {
    logic        av;
    logic [1:0]  a;
    logic        fl;
    logic        rdy;
    logic        exp_valid;
    logic [29:0] exp_buf;
    logic [3:0]  exp_cnt;
  } vec_t;

  word_t sb[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  // Reference state: atoms gathered so far, output occupancy, pending flush, drops
  logic [29:0] m_acc;
  int          m_cnt;
  logic        m_out_v;
  logic        m_pend;
  int          m_dc;
  logic        exp_drop;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_acc = '0; m_cnt = 0; m_out_v = 1'b0; m_pend = 1'b0; m_dc = 0; exp_drop = 1'b0;
    sb.delete();
  endtask

  task automatic step(input logic av, input logic [1:0] a, input logic fl, input logic rdy);
    word_t w;
    logic  slot;
    atom_valid = av; atom = a; flush = fl; word_ready = rdy;
    if (word_valid && word_ready) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL word_unexpected: got buf 0x%0h cnt %0d, expected no word", dct_buffer, dct_count);
      end else begin
        w = sb.pop_front();
        n_checks--;
        chk("word_buf", {2'b00, dct_buffer}, {2'b00, w.buf_v});
        chk("word_cnt", {28'd0, dct_count}, {28'd0, w.cnt});
      end
    end
    slot     = !m_out_v || rdy;
    exp_drop = 1'b0;
    if (av) begin
      if (m_cnt < 15) begin
        m_acc[2*m_cnt +: 2] = a;
        m_cnt++;
      end else begin
        exp_drop = 1'b1;
        if (m_dc < DC_MAX) m_dc++;
      end
    end
    if (slot && (m_cnt == 15 || ((fl || m_pend) && m_cnt > 0))) begin
      w.buf_v = m_acc; w.cnt = 4'(m_cnt);
      sb.push_back(w);
      m_out_v = 1'b1; m_acc = '0; m_cnt = 0; m_pend = 1'b0;
    end else begin
      if (fl && m_cnt > 0) m_pend = 1'b1;
      if (rdy) m_out_v = 1'b0;
    end
    @(posedge clk); #1;
    chk("atom_drop", {31'd0, atom_drop}, {31'd0, exp_drop});
    chk("drop_count", {28'd0, drop_count}, 32'(m_dc));
    chk("word_valid", {31'd0, word_valid}, {31'd0, m_out_v});
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_valid"}, {31'd0, word_valid}, 32'd0);
    chk({tag, "_buf"},   {2'b00, dct_buffer}, 32'd0);
    chk({tag, "_cnt"},   {28'd0, dct_count},  32'd0);
    chk({tag, "_drop"},  {31'd0, atom_drop},  32'd0);
    chk({tag, "_dcnt"},  {28'd0, drop_count}, 32'd0);
  endtask

  vec_t tbl[7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b1, 2'd3, 1'b0, 1'b1, 1'b0, 30'h0,  4'd0};
    tbl[1] = '{1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 30'h0,  4'd0};
    tbl[2] = '{1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 30'h0,  4'd0};
    tbl[3] = '{1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 30'h1B, 4'd4};
    tbl[4] = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 30'h0,  4'd0};
    tbl[5] = '{1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 30'h0,  4'd0};
    tbl[6] = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 30'h0,  4'd0};

    reset = 1'b1; atom_valid = 1'b0; atom = 2'd0; flush = 1'b0; word_ready = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    reset = 1'b0;

    // Full word of fifteen 2'b01 atoms
    for (int i = 0; i < 15; i++) step(1'b1, 2'd1, 1'b0, 1'b1);
    chk("full_valid", {31'd0, word_valid}, 32'd1);
    chk("full_buf",   {2'b00, dct_buffer}, 32'h15555555);
    chk("full_cnt",   {28'd0, dct_count},  32'd15);
    step(1'b0, 2'd0, 1'b0, 1'b1);

    // Partial flush, then an empty flush that must not emit
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].av, tbl[i].a, tbl[i].fl, tbl[i].rdy);
      chk($sformatf("tbl%0d_valid", i), {31'd0, word_valid}, {31'd0, tbl[i].exp_valid});
      if (tbl[i].exp_valid) begin
        chk($sformatf("tbl%0d_buf", i), {2'b00, dct_buffer}, {2'b00, tbl[i].exp_buf});
        chk($sformatf("tbl%0d_cnt", i), {28'd0, dct_count},  {28'd0, tbl[i].exp_cnt});
      end
    end

    // Backpressure: one word held, accumulator fills, 31st atom dropped
    for (int i = 0; i < 30; i++) step(1'b1, 2'(i % 4), 1'b0, 1'b0);
    chk("bp_held_cnt", {28'd0, dct_count}, 32'd15);
    step(1'b1, 2'd3, 1'b0, 1'b0);
    chk("bp_drop_pulse", {31'd0, atom_drop}, 32'd1);
    chk("bp_drop_count", {28'd0, drop_count}, (DC_MAX > 0) ? 32'd1 : 32'd0);
    step(1'b0, 2'd0, 1'b0, 1'b0);
    chk("bp_drop_clear", {31'd0, atom_drop}, 32'd0);
    step(1'b0, 2'd0, 1'b0, 1'b1);
    chk("bp_second_valid", {31'd0, word_valid}, 32'd1);
    step(1'b0, 2'd0, 1'b0, 1'b1);

    // Pending flush behind a held word
    for (int i = 0; i < 15; i++) step(1'b1, 2'd2, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)  step(1'b1, 2'(i + 1), 1'b0, 1'b0);
    step(1'b0, 2'd0, 1'b1, 1'b0);
    step(1'b0, 2'd0, 1'b0, 1'b0);
    chk("pend_held_cnt", {28'd0, dct_count}, 32'd15);
    step(1'b0, 2'd0, 1'b0, 1'b1);
    chk("pend_valid", {31'd0, word_valid}, 32'd1);
    chk("pend_cnt",   {28'd0, dct_count},  32'd3);
    chk("pend_buf",   {2'b00, dct_buffer}, 32'h39);
    step(1'b0, 2'd0, 1'b0, 1'b1);

    // Saturation of the drop counter
    for (int i = 0; i < 30; i++) step(1'b1, 2'd1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 2'd3, 1'b0, 1'b0);
    chk("sat_count", {28'd0, drop_count}, (DC_MAX > 0) ? 32'd15 : 32'd0);
    repeat (3) step(1'b0, 2'd0, 1'b0, 1'b1);

    // Reset in the middle of a word
    for (int i = 0; i < 7; i++) step(1'b1, 2'd3, 1'b0, 1'b1);
    #2 reset = 1'b1;
    #1;
    check_zero_outputs("midreset");
    model_clear();
    @(posedge clk); #1;
    reset = 1'b0;
    step(1'b0, 2'd0, 1'b1, 1'b1);
    for (int i = 0; i < 15; i++) step(1'b1, 2'd2, 1'b0, 1'b1);
    chk("post_reset_buf", {2'b00, dct_buffer}, 32'h2AAAAAAA);
    chk("post_reset_cnt", {28'd0, dct_count},  32'd15);
    step(1'b0, 2'd0, 1'b0, 1'b1);
    step(1'b0, 2'd0, 1'b0, 1'b1);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
